// File: rtl/tdc_readout_if.sv
// Bus bundle for the TDC readout back-end: ring/counter capture inputs,
// accumulation/FIFO control and the byte-wide readout.
interface tdc_readout_if #(
  parameter int N_DELAY      = 64,
  parameter int N_CTR        = 16,
  parameter int MAX_AVG_LOG2 = 3
);
  localparam int FW    = $clog2(N_DELAY);
  localparam int SUM_W = N_CTR + 1 + FW + MAX_AVG_LOG2;
  localparam int NB    = (SUM_W + 7) / 8;

  logic [N_DELAY-1:0]                  i_ring;
  logic [N_CTR-1:0]                    i_ctr;
  logic                                i_sample;
  logic [$clog2(MAX_AVG_LOG2+1)-1:0]   i_avg_log2;
  logic                                i_pop;
  logic                                i_clr;
  logic [$clog2(NB+1)-1:0]             i_byte_sel;
  logic [7:0]                          o_data;
  logic                                o_valid;
  logic                                o_ovf;

  modport master (
    output i_ring, i_ctr, i_sample, i_avg_log2, i_pop, i_clr, i_byte_sel,
    input  o_data, o_valid, o_ovf
  );

  modport slave (
    input  i_ring, i_ctr, i_sample, i_avg_log2, i_pop, i_clr, i_byte_sel,
    output o_data, o_valid, o_ovf
  );
endinterface

// File: rtl/tdc_readout.sv
// TDC readout back-end: synchronises the capture request, decodes the ring
// snapshot into a binary timestamp, accumulates 2^k samples and queues the
// sums in a small FIFO exposed one byte at a time.
module tdc_readout #(
  parameter int N_DELAY      = 64,
  parameter int N_CTR        = 16,
  parameter int MAX_AVG_LOG2 = 3,
  parameter int FIFO_DEPTH   = 4
) (
  input logic          clk,
  input logic          rst_n,
  tdc_readout_if.slave bus
);
  localparam int FW    = $clog2(N_DELAY);
  localparam int TS_W  = N_CTR + 1 + FW;
  localparam int SUM_W = TS_W + MAX_AVG_LOG2;
  localparam int NB    = (SUM_W + 7) / 8;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int KW    = $clog2(MAX_AVG_LOG2 + 1);
  localparam int GW    = MAX_AVG_LOG2 + 1;

  logic             r_s1, r_s2, r_s3;
  logic [1:0]       r_vld_pipe;      // [0] capture pulse, [1] timestamp valid
  logic [TS_W-1:0]  r_ts;
  logic [FW-1:0]    w_fine;
  logic [KW-1:0]    w_k_in, w_k, r_k;
  logic [GW-1:0]    r_cnt;
  logic [SUM_W-1:0] r_acc, w_sum;
  logic             w_done;
  logic             r_push;
  logic [SUM_W-1:0] r_push_data;
  logic [SUM_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_ovf;
  logic             w_full, w_empty, w_pop, w_wr;
  logic [NB-1:0][7:0] w_head;
  logic [7:0]       w_data;

  // Two-flop synchroniser plus edge-detect flop; kept across i_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= bus.i_sample;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Fine position: lowest stage whose value differs from its predecessor.
  always_comb begin
    w_fine = '0;
    for (int i = N_DELAY - 1; i >= 1; i--)
      if (bus.i_ring[i] != bus.i_ring[i-1]) w_fine = FW'(i);
  end

  // Capture pulse and timestamp register; i_clr drops anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_ts       <= '0;
    end else if (bus.i_clr) begin
      r_vld_pipe <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[0], r_s2 & ~r_s3};
      if (r_vld_pipe[0]) r_ts <= {bus.i_ctr, bus.i_ring[0], w_fine};
    end
  end

  // k is sampled only on the first sample of a group, clamped to the max.
  assign w_k_in = (int'(bus.i_avg_log2) > MAX_AVG_LOG2) ? KW'(MAX_AVG_LOG2)
                                                        : bus.i_avg_log2;
  assign w_k    = (r_cnt == '0) ? w_k_in : r_k;
  assign w_sum  = r_acc + SUM_W'(r_ts);
  assign w_done = (r_cnt + GW'(1)) == (GW'(1) << w_k);

  // Accumulate timestamps; emit the sum once 2^k samples are in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_k         <= '0;
      r_push      <= 1'b0;
      r_push_data <= '0;
    end else if (bus.i_clr) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_k    <= '0;
      r_push <= 1'b0;
    end else begin
      r_push <= 1'b0;
      if (r_vld_pipe[1]) begin
        if (r_cnt == '0) r_k <= w_k_in;
        if (w_done) begin
          r_push      <= 1'b1;
          r_push_data <= w_sum;
          r_acc       <= '0;
          r_cnt       <= '0;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + GW'(1);
        end
      end
    end
  end

  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = bus.i_pop && !w_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_wr    = r_push && (!w_full || w_pop);

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (bus.i_clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_wr) - CW'(w_pop);
      if (r_push && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  // Storage needs no reset: an empty FIFO never shows its contents.
  always_ff @(posedge clk) begin
    if (w_wr && !bus.i_clr) r_mem[r_wptr] <= r_push_data;
  end

  // Byte mux over the head entry, then the status byte, then zeros.
  always_comb begin
    w_head = (NB*8)'(r_mem[r_rptr]);
    w_data = '0;
    for (int b = 0; b < NB; b++)
      if (int'(bus.i_byte_sel) == b && !w_empty) w_data = w_head[b];
    if (int'(bus.i_byte_sel) == NB)
      w_data = {r_ovf, w_empty, w_full, 5'(r_count)};
  end

  assign bus.o_data  = w_data;
  assign bus.o_valid = !w_empty;
  assign bus.o_ovf   = r_ovf;

endmodule

// File: tb/tb_tdc_readout.sv
// Self-checking bench for tdc_readout: directed test-plan steps followed by
// randomized captures/pops against a queue-based reference model.
module tb_tdc_readout;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tdc_readout_if bus ();
  tdc_readout dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [25:0] q[$];
  logic [25:0] macc;
  int          mcnt;
  int          mk;
  bit          movf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [25:0] ts_of(input logic [63:0] r, input logic [15:0] c);
    logic [63:0] d;
    int f;
    d = r ^ (r >> 1);   // d[j] set where stage j+1 differs from stage j
    f = 0;
    for (int j = 62; j >= 0; j--) if (d[j]) f = j + 1;
    return 26'(c) * 26'd128 + 26'(r[0]) * 26'd64 + 26'(f);
  endfunction

  function automatic logic [7:0] status_exp();
    int n;
    n = q.size();
    return {movf, n == 0, n == 4, 5'(n)};
  endfunction

  task automatic model_reset();
    q.delete();
    macc = '0;
    mcnt = 0;
    mk   = 0;
    movf = 1'b0;
  endtask

  task automatic check_state(input string tag);
    logic [31:0] h;
    int n;
    n = q.size();
    h = (n > 0) ? 32'(q[0]) : 32'd0;
    chk({tag, ":valid"}, 32'(bus.o_valid), 32'(n > 0));
    chk({tag, ":ovf"}, 32'(bus.o_ovf), 32'(movf));
    for (int b = 0; b < 4; b++) begin
      bus.i_byte_sel = 3'(b);
      #1;
      chk($sformatf("%s:b%0d", tag, b), 32'(bus.o_data), 32'(h[8*b +: 8]));
    end
    bus.i_byte_sel = 3'd4;
    #1;
    chk({tag, ":status"}, 32'(bus.o_data), 32'(status_exp()));
    bus.i_byte_sel = 3'd5;
    #1;
    chk({tag, ":sel5"}, 32'(bus.o_data), 32'd0);
  endtask

  task automatic chk_sel(input string tag, input logic [2:0] sel, input logic [7:0] exp);
    bus.i_byte_sel = sel;
    #1;
    chk(tag, 32'(bus.o_data), 32'(exp));
  endtask

  // One capture: edge on i_sample, optional pop landing on the push cycle.
  task automatic capture(input logic [63:0] ring, input logic [15:0] ctr,
                         input logic [1:0] k, input bit popw);
    logic [25:0] ts;
    @(negedge clk);
    bus.i_ring = ring;
    bus.i_ctr = ctr;
    bus.i_avg_log2 = k;
    bus.i_sample = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    // one cycle before the push may land, nothing has changed yet
    chk("lat:valid", 32'(bus.o_valid), 32'(q.size() > 0));
    chk_sel("lat:status", 3'd4, status_exp());
    if (popw) begin
      @(negedge clk);
      bus.i_pop = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.i_pop = 1'b0;
    ts = ts_of(ring, ctr);
    if (popw && q.size() > 0) void'(q.pop_front());
    if (mcnt == 0) mk = (int'(k) > 3) ? 3 : int'(k);
    macc = macc + ts;
    mcnt++;
    if (mcnt == (1 << mk)) begin
      if (q.size() < 4) q.push_back(macc);
      else movf = 1'b1;
      macc = '0;
      mcnt = 0;
    end
    check_state("cap");
    @(negedge clk);
    bus.i_sample = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic do_pop();
    @(negedge clk);
    bus.i_pop = 1'b1;
    @(posedge clk);
    #1;
    bus.i_pop = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
    check_state("pop");
  endtask

  task automatic do_clr();
    @(negedge clk);
    bus.i_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.i_clr = 1'b0;
    model_reset();
    check_state("clr");
  endtask

  initial begin
    logic [63:0] r;
    model_reset();
    bus.i_ring = '0;
    bus.i_ctr = '0;
    bus.i_sample = 1'b0;
    bus.i_avg_log2 = '0;
    bus.i_pop = 1'b0;
    bus.i_clr = 1'b0;
    bus.i_byte_sel = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: single k=0 capture
    capture(64'h00000000000000FF, 16'h0123, 2'd0, 1'b0);
    chk_sel("t1:b0", 3'd0, 8'hC8);
    chk_sel("t1:b1", 3'd1, 8'h91);
    chk_sel("t1:b2", 3'd2, 8'h00);
    chk_sel("t1:b3", 3'd3, 8'h00);
    chk_sel("t1:status", 3'd4, 8'h01);
    do_pop();

    // 2: k=1 pairs into one entry
    capture(64'h00000000000000FF, 16'h0123, 2'd1, 1'b0);
    capture(64'h00000000000003FF, 16'h0123, 2'd1, 1'b0);
    chk_sel("t2:b0", 3'd0, 8'h92);
    chk_sel("t2:b1", 3'd1, 8'h23);
    chk_sel("t2:b2", 3'd2, 8'h01);
    chk_sel("t2:b3", 3'd3, 8'h00);
    do_pop();

    // 3: overflow, then simultaneous push/pop when full
    for (int i = 0; i < 5; i++)
      capture({$urandom, $urandom}, 16'($urandom), 2'd0, 1'b0);
    chk_sel("t3:status", 3'd4, 8'hA4);
    do_clr();
    for (int i = 0; i < 4; i++)
      capture({$urandom, $urandom}, 16'($urandom), 2'd0, 1'b0);
    capture({$urandom, $urandom}, 16'($urandom), 2'd0, 1'b1);
    chk_sel("t3:pushpop", 3'd4, 8'h24);

    // 5: drain past empty
    for (int i = 0; i < 5; i++) do_pop();
    chk_sel("t5:b0", 3'd0, 8'h00);

    // 4: no transition in the ring
    capture(64'h0, 16'h0001, 2'd0, 1'b0);
    chk_sel("t4:b0", 3'd0, 8'h80);
    do_pop();

    // capture discarded by i_clr while in flight
    @(negedge clk);
    bus.i_ring = 64'h0F;
    bus.i_ctr = 16'h0042;
    bus.i_avg_log2 = 2'd0;
    bus.i_sample = 1'b1;
    repeat (4) @(posedge clk);
    do_clr();
    repeat (4) @(posedge clk);
    #1;
    check_state("inflight");
    @(negedge clk);
    bus.i_sample = 1'b0;
    repeat (3) @(posedge clk);

    // 6: partial k=3 group thrown away by i_clr; next 8 form one entry
    for (int i = 0; i < 3; i++)
      capture({$urandom, $urandom}, 16'($urandom), 2'd3, 1'b0);
    do_clr();
    for (int i = 0; i < 8; i++)
      capture({$urandom, $urandom}, 16'($urandom), (i == 0) ? 2'd3 : 2'd0, 1'b0);
    chk("t6:count", 32'(q.size()), 32'd1);
    do_pop();

    // reset mid-group discards the partial sum
    for (int i = 0; i < 2; i++)
      capture({$urandom, $urandom}, 16'($urandom), 2'd2, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++)
      capture({$urandom, $urandom}, 16'($urandom), 2'd2, 1'b0);
    do_pop();

    // randomized mix of thermometer/random rings, k, pops
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        r = '1;
        r = r >> $urandom_range(0, 64);
        if ($urandom_range(0, 1) == 1) r = ~r;
      end else begin
        r = {$urandom, $urandom};
      end
      capture(r, 16'($urandom), 2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) do_pop();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tdc_readout.md
Name: tdc_readout

Overview:
- Parametrised readout back-end for the ring-oscillator TDC.
- Takes the raw delay-ring snapshot and coarse counter from the tdc_ring core, decodes the fine edge position, and forms a binary timestamp.
- Optionally accumulates 2^k measurements into one sum and buffers results in a small FIFO.
- Exposes the FIFO head byte-wise on an 8-bit output, which fits the limited Tiny Tapeout pin budget.

Parameters:
N_DELAY, 64, ring stages; FW = clog2(N_DELAY) fine bits
N_CTR, 16, coarse counter width
MAX_AVG_LOG2, 3, max accumulation exponent; SUM_W = N_CTR+1+FW+MAX_AVG_LOG2
FIFO_DEPTH, 4, result entries (power of 2, >=2); CW = clog2(FIFO_DEPTH)+1
NB (derived), ceil(SUM_W/8), data bytes per entry; defaults give SUM_W=26, NB=4

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
i_ring  in  N_DELAY  raw ring snapshot from tdc_ring; stable while i_sample is high
i_ctr  in  N_CTR  raw coarse count from tdc_ring; stable while i_sample is high
i_sample  in  1  asynchronous level; rising edge requests one capture
i_avg_log2  in  clog2(MAX_AVG_LOG2+1)  accumulation exponent k; values above MAX are clamped
i_pop  in  1  clk-domain, one-cycle pulse; discards the FIFO head
i_clr  in  1  clk-domain synchronous clear
i_byte_sel  in  clog2(NB+1)  output byte select
o_data  out  8  selected byte (combinational from registers)
o_valid  out  1  FIFO not empty
o_ovf  out  1  sticky overflow flag

Behaviour:
- Reset (rst_n low, async):
  - FIFO empty; accumulator, sample counter, synchronisers and o_ovf cleared.
  - o_valid=0, o_data=0.
- i_sample path:
  - Two-flop synchroniser, then a third flop for rising-edge detect; produces a single-cycle cap pulse (cycle 3 after the edge).
  - The cap pulse registers i_ring and i_ctr, decoded as below (cycle 4).
- Decode:
  - ph = ring[0].
  - fine = lowest i in 1..N_DELAY-1 with ring[i] != ring[i-1]; 0 if no transition exists.
  - ts = {ctr, ph, fine}, width N_CTR+1+FW, zero-extended to SUM_W.
- Accumulate (cycle 5):
  - On the first sample of a group (sample count==0), k is latched from i_avg_log2, clamped to MAX_AVG_LOG2.
  - Later changes to i_avg_log2 are ignored until the group completes.
  - acc += ts; count += 1.
  - When count reaches 2^k, the final sum (acc+ts) is pushed, acc is reset and count is reset.
  - k=0 pushes every sample.
  - acc cannot overflow by construction.
- FIFO:
  - A pushed entry is visible at the head in cycle 6 after the i_sample edge.
  - Push while full and no pop in the same cycle: entry dropped, o_ovf set.
  - Push and pop in the same cycle while full: both performed, no overflow.
  - Pop while empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Readout:
  - i_byte_sel = b < NB: o_data = head[8b+7:8b]. The top byte is zero-padded. If empty, o_data=0.
  - i_byte_sel = NB: status byte = {o_ovf, ~o_valid, full, count[CW-1:0] in bits 4:0, zero-padded}.
  - i_byte_sel > NB: o_data=0.
- i_clr:
  - Same effect as reset, except the synchronisers are kept.
  - Takes priority over a simultaneous push or pop.
  - A capture in flight during i_clr is discarded.
- Reset mid-group discards any partial accumulation.

Test Plan:
1. k=0, i_ctr=0x0123, i_ring=64'h00000000000000FF, rise i_sample
   -> fine=8, ph=1, entry 0x91C8 at cycle 6.
   -> Bytes 0..3: C8,91,00,00.
   -> Status (sel=4): 0x01. o_valid=1.
2. k=1; two captures, ctr 0x0123, ring fine 8 then fine 10 (ring=..03FF)
   -> No push after the first capture.
   -> A single entry 0x12392 after the second: bytes 92,23,01,00.
3. Five k=0 captures with no pop (DEPTH=4)
   -> 4 entries; status 0xA4 (ovf, full, count=4).
   -> Head still equals the first capture.
   -> Pop with a simultaneous push when full: count stays 4, no extra overflow.
4. Ring all zeros (no transition), ctr 0x0001
   -> fine=0, ph=0, entry 0x80.
5. Pop 5 times from 4 entries
   -> count decrements 4,3,2,1,0; the 5th pop is ignored; o_valid=0, o_data=0 on data bytes.
6. k=3, 3 captures, then i_clr (or rst_n low)
   -> FIFO empty, o_ovf=0.
   -> The next 8 captures produce exactly one entry, the sum of those 8.
